serial_adder_ctrl: RTL and testbench

Bit-serial addition controller that time-shares one full-adder bit cell (Sum = A^B^Cin, Carry = majority(A,B,Cin)) across all bits of a WIDTH-bit operand pair. It processes bits LSB-first, one bit per clock, and keeps the inter-bit carry in a flip-flop. It uses a start/busy/done handshake and registers the result. It sits between a requesting datapath and the single-bit adder resource, trading latency for area.

---
 rtl/serial_adder_ctrl.sv | 100 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused LSB-first over WIDTH bits.
// Latency: WIDTH cycles from accepting edge to done; done lasts one cycle, then IDLE.
// Backpressure: start is sampled only in IDLE; requests during SHIFT/DONE are dropped.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One extra counter bit keeps WIDTH=1 legal (clog2(1)=0).
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) + 1 : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic             bit_sum;
  logic             bit_carry;
  logic [CW-1:0]    cnt;

  // Shared full-adder cell and the sum register with the new bit inserted at the MSB.
  always_comb begin
    bit_sum             = a_sr[0] ^ b_sr[0] ^ carry;
    bit_carry           = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    sum_next            = sum_sr >> 1;
    sum_next[WIDTH-1]   = bit_sum;
  end

  // Control FSM with registered busy/done and result capture on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            carry  <= cin;
            sum_sr <= '0;
            cnt    <= '0;
            state  <= SHIFT;
            busy   <= 1'b1;
          end
        end
        SHIFT: begin
          sum_sr <= sum_next;
          carry  <= bit_carry;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= sum_next;
            cout  <= bit_carry;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8, 1 and 16.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// All waits on done are bounded by a cycle budget.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request on the 8-bit instance; returns 1 time unit after the accepting edge.
  task automatic op8_start(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    start16 = 0; a16 = 0; b16 = 0; cin16 = 0;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy8, done8, cout8, sum8} !== 11'h0)
      $display("FAIL reset_w8 got busy=%b done=%b cout=%b sum=%h want all 0", busy8, done8, cout8, sum8);
    else pass_cnt++;
    total_cnt++;
    if ({busy1, done1, cout1, sum1} !== 4'h0)
      $display("FAIL reset_w1 got busy=%b done=%b cout=%b sum=%h want all 0", busy1, done1, cout1, sum1);
    else pass_cnt++;
    total_cnt++;
    if ({busy16, done16, cout16, sum16} !== 19'h0)
      $display("FAIL reset_w16 got busy=%b done=%b cout=%b sum=%h want all 0", busy16, done16, cout16, sum16);
    else pass_cnt++;
    tick(); tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total_cnt++;
      if ({busy8, done8, cout8, sum8} !== 11'h0)
        $display("FAIL idle_%0d got busy=%b done=%b cout=%b sum=%h want all 0", i, busy8, done8, cout8, sum8);
      else pass_cnt++;
    end
  endtask

  task automatic test_carry_ripple();
    op8_start(8'hFF, 8'h01, 1'b0);
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if ({busy8, done8} !== 2'b10)
        $display("FAIL ripple_busy_k+%0d got busy=%b done=%b want busy=1 done=0", i, busy8, done8);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if ({busy8, done8, cout8, sum8} !== {2'b01, 1'b1, 8'h00})
      $display("FAIL ripple_done got busy=%b done=%b cout=%b sum=%h want 0 1 1 00", busy8, done8, cout8, sum8);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy8, done8} !== 2'b00)
      $display("FAIL ripple_after got busy=%b done=%b want 0 0", busy8, done8);
    else pass_cnt++;
  endtask

  task automatic test_full_carry();
    op8_start(8'hA5, 8'h5A, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    total_cnt++;
    if ({done8, cout8, sum8} !== {1'b1, 1'b1, 8'h00})
      $display("FAIL fullcarry_1 got done=%b cout=%b sum=%h want 1 1 00", done8, cout8, sum8);
    else pass_cnt++;
    tick();
    op8_start(8'h3C, 8'h42, 1'b0);
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if ({busy8, cout8, sum8} !== {1'b1, 1'b1, 8'h00})
        $display("FAIL fullcarry_hold_k+%0d got busy=%b cout=%b sum=%h want 1 1 00", i, busy8, cout8, sum8);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if ({done8, cout8, sum8} !== {1'b1, 1'b0, 8'h7E})
      $display("FAIL fullcarry_2 got done=%b cout=%b sum=%h want 1 0 7e", done8, cout8, sum8);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_ignored_start();
    int ndone = 0;
    int nrise = 0;
    logic prev_busy;
    logic [8:0] got = '0;
    op8_start(8'h10, 8'h20, 1'b0);
    a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
    prev_busy = busy8;
    tick();
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (done8) begin
        ndone++;
        got = {cout8, sum8};
      end
      if (busy8 && !prev_busy) nrise++;
      prev_busy = busy8;
      tick();
    end
    total_cnt++;
    if (ndone !== 1) $display("FAIL ignored_done_count got %0d want 1", ndone);
    else pass_cnt++;
    total_cnt++;
    if (got !== 9'h030) $display("FAIL ignored_result got %h want 030", got);
    else pass_cnt++;
    total_cnt++;
    if (nrise !== 0) $display("FAIL ignored_extra_op got %0d extra busy rises want 0", nrise);
    else pass_cnt++;
  endtask

  task automatic test_held_start();
    int rises[4];
    int nr = 0;
    logic prev_busy = 1'b0;
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (busy8 && !prev_busy && nr < 4) begin
        rises[nr] = c;
        nr++;
      end
      prev_busy = busy8;
    end
    start8 = 1'b0;
    total_cnt++;
    if (nr < 3) $display("FAIL held_accepts got %0d accepts want >= 3", nr);
    else pass_cnt++;
    if (nr >= 3) begin
      total_cnt++;
      if (rises[1] - rises[0] !== 10) $display("FAIL held_spacing_1 got %0d want 10", rises[1] - rises[0]);
      else pass_cnt++;
      total_cnt++;
      if (rises[2] - rises[1] !== 10) $display("FAIL held_spacing_2 got %0d want 10", rises[2] - rises[1]);
      else pass_cnt++;
    end
    for (int i = 0; i < 12; i++) tick();
    total_cnt++;
    if ({busy8, cout8, sum8} !== {1'b0, 1'b0, 8'h03})
      $display("FAIL held_result got busy=%b cout=%b sum=%h want 0 0 03", busy8, cout8, sum8);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    op8_start(8'h3C, 8'h42, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    op8_start(8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy8, done8, cout8, sum8} !== 11'h0)
      $display("FAIL midreset_clear got busy=%b done=%b cout=%b sum=%h want all 0", busy8, done8, cout8, sum8);
    else pass_cnt++;
    tick(); tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 || busy8) ndone++;
    end
    total_cnt++;
    if (ndone !== 0) $display("FAIL midreset_no_done got %0d active cycles want 0", ndone);
    else pass_cnt++;
    op8_start(8'h80, 8'h80, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    total_cnt++;
    if ({done8, cout8, sum8} !== {1'b1, 1'b1, 8'h00})
      $display("FAIL midreset_next got done=%b cout=%b sum=%h want 1 1 00", done8, cout8, sum8);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_width1();
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    total_cnt++;
    if ({busy1, done1} !== 2'b10) $display("FAIL w1_busy got busy=%b done=%b want 1 0", busy1, done1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy1, done1, cout1, sum1} !== 4'b0111)
      $display("FAIL w1_done got busy=%b done=%b cout=%b sum=%b want 0 1 1 1", busy1, done1, cout1, sum1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy1, done1} !== 2'b00) $display("FAIL w1_after got busy=%b done=%b want 0 0", busy1, done1);
    else pass_cnt++;
  endtask

  task automatic test_sweep8();
    logic [8:0] exp;
    for (int n = 0; n < 500; n++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      exp = {1'b0, a8} + {1'b0, b8} + {8'h0, cin8};
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int t = 0; t < 20 && !done8; t++) tick();
      total_cnt++;
      if (!done8 || {cout8, sum8} !== exp)
        $display("FAIL sweep8_%0d got done=%b result=%h want done=1 result=%h", n, done8, {cout8, sum8}, exp);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_sweep16();
    logic [16:0] exp;
    for (int n = 0; n < 500; n++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      exp = {1'b0, a16} + {1'b0, b16} + {16'h0, cin16};
      start16 = 1'b1;
      tick();
      start16 = 1'b0;
      for (int t = 0; t < 30 && !done16; t++) tick();
      total_cnt++;
      if (!done16 || {cout16, sum16} !== exp)
        $display("FAIL sweep16_%0d got done=%b result=%h want done=1 result=%h", n, done16, {cout16, sum16}, exp);
      else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_full_carry();
    test_ignored_start();
    test_held_start();
    test_reset_mid();
    test_width1();
    test_sweep8();
    test_sweep16();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
